// File: rtl/fir_interp_pkg.sv
// -----------------------------------------------------------------------------
// fir_interp_pkg
// Shared constants and helpers for the polyphase interpolating FIR:
//   - default geometry (taps, interpolation factor, sample width)
//   - BITS quantisation shift and the DEQUANTIZE helper (truncate toward zero)
//   - the 32-entry interpolation coefficient table
//   - the controller state encoding
// -----------------------------------------------------------------------------
package fir_interp_pkg;

  localparam int DATA_SIZE_DEF = 32;
  localparam int TAPS_DEF      = 32;
  localparam int INTERP_DEF    = 8;
  localparam int PROD_W        = 2 * DATA_SIZE_DEF;

  // Coefficients are fixed-point with BITS fractional bits.
  localparam int BITS = 10;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  // Interpolation low-pass, indexed by natural tap order h[0..31].
  // Phase k uses h[k], h[k+8], h[k+16], h[k+24].
  localparam logic signed [DATA_SIZE_DEF-1:0] INTERP_COEFFS [0:TAPS_DEF-1] = '{
    32'sd1,   -32'sd3,  -32'sd8,  -32'sd12, -32'sd10, 32'sd0,   32'sd22,  32'sd56,
    32'sd102, 32'sd160, 32'sd228, 32'sd302, 32'sd378, 32'sd450, 32'sd512, 32'sd557,
    32'sd580, 32'sd577, 32'sd548, 32'sd496, 32'sd428, 32'sd350, 32'sd270, 32'sd194,
    32'sd128, 32'sd75,  32'sd36,  32'sd11,  -32'sd2,  -32'sd7,  -32'sd6,  -32'sd3
  };

  // Divide a full-width product by 2^BITS, rounding toward zero.
  // An arithmetic shift floors, so negative values are biased by 2^BITS-1
  // first to turn the floor into a truncation.
  function automatic logic signed [DATA_SIZE_DEF-1:0] dequantize(
    input logic signed [PROD_W-1:0] prod
  );
    logic signed [PROD_W-1:0] biased;
    if (prod < 0) begin
      biased = prod + ((64'sd1 <<< BITS) - 64'sd1);
    end else begin
      biased = prod;
    end
    return DATA_SIZE_DEF'(biased >>> BITS);
  endfunction

endpackage

// File: rtl/fir_interp_if.sv
// -----------------------------------------------------------------------------
// fir_interp_if
// FIFO-facing handshake bundle of the interpolating FIR.
//   x_in       : input sample (first-word-fall-through, valid when !x_empty)
//   x_empty    : input FIFO empty
//   x_rd_en    : pop input FIFO
//   y_out      : output sample
//   y_out_full : output FIFO full
//   y_wr_en    : push output FIFO
// Modports: master = filter side, slave = FIFO/environment side.
// -----------------------------------------------------------------------------
interface fir_interp_if
  import fir_interp_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
);

  logic signed [DATA_SIZE-1:0] x_in;
  logic                        x_empty;
  logic                        x_rd_en;
  logic signed [DATA_SIZE-1:0] y_out;
  logic                        y_out_full;
  logic                        y_wr_en;

  modport master (
    input  x_in,
    input  x_empty,
    output x_rd_en,
    output y_out,
    input  y_out_full,
    output y_wr_en
  );

  modport slave (
    output x_in,
    output x_empty,
    input  x_rd_en,
    input  y_out,
    output y_out_full,
    input  y_wr_en
  );

endinterface

// File: rtl/fir_interp.sv
// -----------------------------------------------------------------------------
// fir_interp
// Polyphase interpolating FIR. Each popped input sample yields INTERPOLATION
// output samples; phase k is sum_j DQ(hist[j] * h[k + j*INTERPOLATION]),
// accumulated one tap per cycle in DATA_SIZE bits with wrap-around.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : fir_interp_if.master (input FIFO pop side, output FIFO push side)
// x_rd_en and y_wr_en are combinational from state and FIFO flags; y_out is
// registered and held stable while waiting in S_WRITE.
// -----------------------------------------------------------------------------
module fir_interp
  import fir_interp_pkg::*;
#(
  parameter int TAPS          = TAPS_DEF,
  parameter int INTERPOLATION = INTERP_DEF,
  parameter int DATA_SIZE     = DATA_SIZE_DEF
) (
  input  logic         clock,
  input  logic         reset,
  fir_interp_if.master bus
);

  localparam int P     = TAPS / INTERPOLATION;
  localparam int PH_W  = (INTERPOLATION > 1) ? $clog2(INTERPOLATION) : 1;
  localparam int TAP_W = (P > 1) ? $clog2(P) : 1;
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PW    = 2 * DATA_SIZE;

  if ((TAPS % INTERPOLATION) != 0) begin : g_taps_multiple
    $error("fir_interp: TAPS must be a multiple of INTERPOLATION");
  end
  if (TAPS > TAPS_DEF) begin : g_taps_table
    $error("fir_interp: TAPS exceeds the coefficient table size");
  end

  state_t                      r_state;
  state_t                      w_state_next;
  logic signed [DATA_SIZE-1:0] r_hist [0:P-1];
  logic signed [DATA_SIZE-1:0] r_acc;
  logic        [PH_W-1:0]      r_phase;
  logic        [TAP_W-1:0]     r_tap;
  logic signed [DATA_SIZE-1:0] r_y_out;

  logic                        w_rd_en;
  logic                        w_wr_en;
  logic                        w_last_tap;
  logic                        w_last_phase;
  logic        [IDX_W-1:0]     w_coef_idx;
  logic signed [DATA_SIZE-1:0] w_coef;
  logic signed [DATA_SIZE-1:0] w_hist_sel;
  logic signed [PW-1:0]        w_prod;
  logic signed [DATA_SIZE-1:0] w_acc_next;

  assign w_last_tap   = (r_tap == TAP_W'(P - 1));
  assign w_last_phase = (r_phase == PH_W'(INTERPOLATION - 1));

  // Polyphase coefficient for the current phase/tap: h[phase + tap*L].
  assign w_coef_idx = IDX_W'(r_phase) + IDX_W'(r_tap) * IDX_W'(INTERPOLATION);
  assign w_coef     = INTERP_COEFFS[w_coef_idx];
  assign w_hist_sel = r_hist[r_tap];
  assign w_prod     = PW'(w_hist_sel) * PW'(w_coef);
  assign w_acc_next = r_acc + dequantize(w_prod);

  assign bus.x_rd_en = w_rd_en;
  assign bus.y_wr_en = w_wr_en;
  assign bus.y_out   = r_y_out;

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and FIFO strobes; strobes are gated by reset so nothing
  // moves while the block is held in reset.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      S_READ: begin
        if (reset && !bus.x_empty) begin
          w_rd_en      = 1'b1;
          w_state_next = S_MAC;
        end else begin
          w_state_next = S_READ;
        end
      end
      S_MAC: begin
        if (w_last_tap) begin
          w_state_next = S_WRITE;
        end else begin
          w_state_next = S_MAC;
        end
      end
      S_WRITE: begin
        if (reset && !bus.y_out_full) begin
          w_wr_en      = 1'b1;
          w_state_next = w_last_phase ? S_READ : S_MAC;
        end else begin
          w_state_next = S_WRITE;
        end
      end
      default: begin
        w_state_next = S_READ;
      end
    endcase
  end

  // Datapath: history shift on pop, tap-serial MAC, output register, and
  // phase/tap sequencing after each push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < P; j++) begin
        r_hist[j] <= '0;
      end
      r_acc   <= '0;
      r_phase <= '0;
      r_tap   <= '0;
      r_y_out <= '0;
    end else begin
      case (r_state)
        S_READ: begin
          if (w_rd_en) begin
            for (int j = P - 1; j > 0; j--) begin
              r_hist[j] <= r_hist[j-1];
            end
            r_hist[0] <= bus.x_in;
            r_phase   <= '0;
            r_tap     <= '0;
            r_acc     <= '0;
          end
        end
        S_MAC: begin
          if (w_last_tap) begin
            r_y_out <= w_acc_next;
          end else begin
            r_acc <= w_acc_next;
            r_tap <= r_tap + TAP_W'(1);
          end
        end
        S_WRITE: begin
          if (w_wr_en && !w_last_phase) begin
            r_phase <= r_phase + PH_W'(1);
            r_acc   <= '0;
            r_tap   <= '0;
          end
        end
        default: begin
          r_acc <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fir_interp.md
Name: fir_interp

Overview:
- Polyphase interpolating FIR filter, the upsampling counterpart of the decimating FIR in the FM radio datapath.
- Pops one sample from an upstream FIFO and pushes INTERPOLATION filtered samples to a downstream FIFO.
- Mathematically equivalent to zero-stuffing by INTERPOLATION followed by a TAPS-tap FIR.
- Sits between FIFOs in a top wrapper identical in structure to the decimator's wrapper (16-deep FIFOs).

Parameters:
TAPS, 32, total filter taps; must be a multiple of INTERPOLATION (elaboration-time assertion).
INTERPOLATION, 8, output samples produced per input sample (L).
DATA_SIZE, 32, signed sample/coefficient width.

Ports:
clock  in  1  sole clock; all state on rising edge.
reset  in  1  asynchronous, active-low reset.
x_in  in  DATA_SIZE  signed input sample; valid whenever x_empty=0 (first-word-fall-through FIFO).
x_empty  in  1  input FIFO empty.
x_rd_en  out  1  pop input FIFO; combinational, asserted only in S_READ with x_empty=0.
y_out  out  DATA_SIZE  signed output sample; registered.
y_out_full  in  1  output FIFO full.
y_wr_en  out  1  push output FIFO; combinational, asserted only in S_WRITE with y_out_full=0.

Behaviour:
- P = TAPS/INTERPOLATION taps per phase (default 4).
- History register hist[0..P-1] holds the newest P input samples, with hist[0] newest.
- Output for phase k (0..L-1) is the sum over j=0..P-1 of DQ(hist[j]*h[k+j*L]).
- Product width is 2*DATA_SIZE signed.
- DQ divides by 2^BITS, truncating toward zero.
- Accumulation is in DATA_SIZE bits with two's-complement wrap and no saturation.
- State machine:
  - S_READ: if x_empty=0, assert x_rd_en, shift x_in into hist[0] (hist[j]<=hist[j-1]), set phase=0, tap=0, acc=0, then go to S_MAC. Otherwise stay, with no pop.
  - S_MAC: one multiply-accumulate per cycle using tap index tap. After tap=P-1, register acc+final product into y_out and go to S_WRITE. Takes P cycles.
  - S_WRITE: hold y_out stable. If y_out_full=0, assert y_wr_en for exactly one cycle. Then:
    - if phase=L-1, go to S_READ;
    - otherwise increment phase, clear acc and tap, and go to S_MAC.
    - If y_out_full=1, stay in S_WRITE with y_wr_en=0 and no state change.
- Throughput with no stalls: 1 + L*(P+1) cycles per input sample (41 at defaults).
- Latency from pop to first push is P+1 cycles.
- Exactly L pushes occur between consecutive pops, and a pop never overlaps a push.
- Reset (asserted at any time, including mid-phase or mid-stall):
  - state=S_READ; hist, acc, phase, tap, y_out all 0; x_rd_en=0, y_wr_en=0.
  - A partially computed output is discarded, never pushed.
- After reset deassertion, the first pop may occur on the first edge with x_empty=0.
- Filter startup: hist starts at zero, so the first P-1 inputs produce transient outputs computed against zero history. There is no priming suppression.

Decomposition:
- Shared FM radio package (extend the existing one) holds:
  - BITS = 10 (quantisation shift);
  - the interpolation coefficient array INTERP_COEFFS[0..TAPS-1] of signed DATA_SIZE values;
  - the DEQUANTIZE function (truncate toward zero);
  - the state enum {S_READ, S_MAC, S_WRITE}.
- No sub-module; polyphase coefficient index k+tap*L is computed inline.
- Top wrapper fir_interp_top (in FIFO, fir_interp, out FIFO) is a separate file and is not part of this block.

Test Plan:
- Impulse: push 1024 then 3 zeros (BITS=10), sink always ready -> 32 outputs equal INTERP_COEFFS[0], [1], ..., [31] in order; exactly 4 pops.
- DC: push 8 samples of 1024 -> outputs 25..32 (from the 4th input onward) equal, per phase k, the sum over j of INTERP_COEFFS[k+8j], repeating with period 8.
- Negative truncation: single coefficient tap with product -1536 -> contributes -1, not -2. Check via impulse of -1536 against a coefficient of 1.
- Backpressure: hold y_out_full=1 for 20 cycles in S_WRITE -> y_wr_en=0, y_out unchanged, no pop. On release, exactly one push, then normal flow with no sample lost or duplicated versus the golden model.
- Starvation: x_empty=1 for 50 cycles between inputs -> no x_rd_en, no y_wr_en, history preserved. The next input resumes a correct sequence.
- Reset mid-operation: assert reset during S_MAC of phase 3 -> next cycle all outputs 0. After release, an impulse of 1024 reproduces the clean impulse response with no stale history.
